csr_file: RTL
=============

# csr_file

Parametrised machine-mode CSR file and interrupt controller for the PYGMY-V32I core, sitting beside the execute stage. It supports full CSR write/set/clear semantics, a configurable number of external interrupt lines, and mstatus-based global interrupt enable with trap-entry and mret state handling. It also provides free-running 64-bit cycle and retired-instruction counters, and computes the trap target PC in direct or vectored mode.

## Interface
- N_IRQ, 6, number of external interrupt lines (1..16)
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset
- i_CLK  in  1  core clock, all state on rising edge
- i_RSTn  in  1  asynchronous active-low reset
- i_CSR_CMD  in  2  00 none, 01 write, 10 set, 11 clear
- i_CSR_ADDR  in  12  CSR address
- i_CSR_WDATA  in  32  write/set/clear operand
- o_CSR_RD  out  32  current value of addressed CSR (combinational)
- i_PC  in  32  PC of instruction in execute
- i_INSTR  in  32  instruction in execute
- i_RETIRE  in  1  one instruction retires this cycle
- i_MRET  in  1  mret executes this cycle
- i_MEI  in  N_IRQ  level external interrupt requests
- o_IRQ  out  1  trap is taken this cycle
- o_TRAP_PC  out  32  handler target PC
- o_EPC  out  32  mepc

## Operation
- CSR map:
  - 0x300 mstatus: MIE bit 3, MPIE bit 7, other bits read 0.
  - 0x304 mie: bits [N_IRQ-1:0].
  - 0x305 mtvec.
  - 0x340 mscratch.
  - 0x341 mepc: bits [1:0] hardwired 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0x344 mip: read-only, bits [N_IRQ-1:0].
  - 0xB00/0xB80 mcycle low/high.
  - 0xB02/0xB82 minstret low/high.
- Unmapped address: reads 0, writes ignored. Writes to mip are ignored.
- Write updates: write new=WDATA; set new=old|WDATA; clear new=old&~WDATA. Set/clear with WDATA==0 is no write (no side effects, counters keep counting).
- mip[k] is i_MEI[k] registered once. Pending vector p = mip & mie[N_IRQ-1:0].
- Take condition: o_IRQ = mstatus.MIE & |p & ~i_MRET.
- On take, at the next edge:
  - mepc <= {i_PC[31:2],2'b00}
  - mtval <= i_INSTR
  - mcause <= {1'b1, 31'(k)}, where k is the lowest-index set bit of p
  - MPIE <= MIE, MIE <= 0
- On i_MRET, at the next edge: MIE <= MPIE, MPIE <= 1.
- o_TRAP_PC = {mtvec[31:2],2'b00} in direct mode; mtvec base + 4*k in vectored mode. k is the cause computed in the same cycle.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when i_RETIRE=1.
  - Both are 64-bit and wrap from 2^64-1 to 0.

## Timing
- Reset (async assert): all CSRs and mip are 0, mtvec = MTVEC_RESET. o_IRQ=0, o_EPC=0. o_CSR_RD follows address with reset contents.
- Reads have zero latency. Writes become visible the cycle after the edge.
- Interrupt latency: i_MEI sampled high at edge n (with MIE and mie set) gives o_IRQ=1 after edge n. o_IRQ is a one-cycle pulse because MIE clears at edge n+1.
- Simultaneous events:
  - Trap and software write to mstatus/mepc/mcause/mtval in the same cycle: trap update wins; writes to other CSRs proceed.
  - mret and pending interrupt in the same cycle: mret wins, no take. The interrupt can be taken the following cycle if MPIE restored MIE=1.
  - Software write to a counter half: that half takes the new value, the other half holds, and no increment occurs that cycle.
- Reset asserted mid-trap discards the trap; MIE=0 after release.

## Configuration
- CSR_VECTORED_EN defined:
  - mtvec[1:0] is writable as mode; mode 1 is vectored, modes 2/3 behave as direct.
- CSR_VECTORED_EN undefined:
  - mtvec[1:0] is hardwired 0, reads 0, and the target is always direct.

## Test plan
- Reset, then read every mapped address: all 0 except mtvec=MTVEC_RESET; mcycle low reads 5 five cycles after reset release.
- mscratch: write 0xF0F0_0000, set 0x0000_000F, clear 0xF000_0000; reads give 0xF0F0_0000, 0xF0F0_000F, 0x00F0_000F.
- mtvec=0x100, mie=0x24, MIE=1, pulse i_MEI[2] and i_MEI[5] together with i_PC=0x203:
  - o_IRQ pulses once, o_TRAP_PC=0x100.
  - Then mcause=0x8000_0002, mepc=0x200, MIE=0, MPIE=1.
- With CSR_VECTORED_EN defined, mtvec=0x101 and i_MEI[5] alone: o_TRAP_PC=0x114. Undefined: o_TRAP_PC=0x100 and mtvec reads 0x100.
- i_MRET coincident with pending interrupt and MIE=1: no o_IRQ that cycle. After mret, MIE=MPIE restored, and o_IRQ fires next cycle.
- Write mcycle low=0xFFFF_FFFF, high=0: the following cycle reads high=1, low=0. minstret unchanged while i_RETIRE=0.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file and interrupt controller for PYGMY-V32I.
// Define CSR_VECTORED_EN to make mtvec[1:0] a writable mode field (mode 1 = vectored).
module csr_file #(
  parameter int          N_IRQ       = 6,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [1:0]       i_CSR_CMD,
  input  logic [11:0]      i_CSR_ADDR,
  input  logic [31:0]      i_CSR_WDATA,
  output logic [31:0]      o_CSR_RD,
  input  logic [31:0]      i_PC,
  input  logic [31:0]      i_INSTR,
  input  logic             i_RETIRE,
  input  logic             i_MRET,
  input  logic [N_IRQ-1:0] i_MEI,
  output logic             o_IRQ,
  output logic [31:0]      o_TRAP_PC,
  output logic [31:0]      o_EPC
);

  logic             mst_mie;
  logic             mst_mpie;
  logic [N_IRQ-1:0] mie_q;
  logic [N_IRQ-1:0] mip_q;
  logic [N_IRQ-1:0] pend;
  logic [31:2]      mtvec_base;
`ifdef CSR_VECTORED_EN
  logic [1:0]       mtvec_mode;
`endif
  logic [31:0]      mscratch;
  logic [31:2]      mepc_q;
  logic [31:0]      mcause;
  logic [31:0]      mtval;
  logic [63:0]      mcycle;
  logic [63:0]      minstret;
  logic [31:0]      mtvec_rd;
  logic [31:0]      rd_val;
  logic [31:0]      wr_val;
  logic             wr_en;
  logic             cyc_wr;
  logic             ins_wr;
  logic             take;
  logic [3:0]       cause_k;
  logic             unused_pc;

  assign unused_pc = ^i_PC[1:0];

`ifdef CSR_VECTORED_EN
  assign mtvec_rd = {mtvec_base, mtvec_mode};
`else
  assign mtvec_rd = {mtvec_base, 2'b00};
`endif

  always_comb begin
    rd_val = '0;
    case (i_CSR_ADDR)
      12'h300: rd_val = {24'd0, mst_mpie, 3'd0, mst_mie, 3'd0};
      12'h304: rd_val = 32'(mie_q);
      12'h305: rd_val = mtvec_rd;
      12'h340: rd_val = mscratch;
      12'h341: rd_val = {mepc_q, 2'b00};
      12'h342: rd_val = mcause;
      12'h343: rd_val = mtval;
      12'h344: rd_val = 32'(mip_q);
      12'hB00: rd_val = mcycle[31:0];
      12'hB80: rd_val = mcycle[63:32];
      12'hB02: rd_val = minstret[31:0];
      12'hB82: rd_val = minstret[63:32];
      default: rd_val = '0;
    endcase
  end

  assign o_CSR_RD = rd_val;

  // Set/clear with a zero operand is treated as a read only, so it never blocks counting.
  always_comb begin
    wr_val = rd_val;
    case (i_CSR_CMD)
      2'b01:   wr_val = i_CSR_WDATA;
      2'b10:   wr_val = rd_val | i_CSR_WDATA;
      2'b11:   wr_val = rd_val & ~i_CSR_WDATA;
      default: wr_val = rd_val;
    endcase
  end

  assign wr_en  = (i_CSR_CMD == 2'b01) | (i_CSR_CMD[1] & (|i_CSR_WDATA));
  assign cyc_wr = wr_en & ((i_CSR_ADDR == 12'hB00) | (i_CSR_ADDR == 12'hB80));
  assign ins_wr = wr_en & ((i_CSR_ADDR == 12'hB02) | (i_CSR_ADDR == 12'hB82));

  assign pend = mip_q & mie_q;

  // Scan downward so the lowest pending line ends up as the cause.
  always_comb begin
    cause_k = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) cause_k = 4'(i);
    end
  end

  assign take  = mst_mie & (|pend) & ~i_MRET;
  assign o_IRQ = take;
  assign o_EPC = {mepc_q, 2'b00};

`ifdef CSR_VECTORED_EN
  assign o_TRAP_PC = (mtvec_mode == 2'b01) ? ({mtvec_base, 2'b00} + {26'd0, cause_k, 2'b00})
                                           : {mtvec_base, 2'b00};
`else
  assign o_TRAP_PC = {mtvec_base, 2'b00};
`endif

  // Trap entry and mret are placed last so they override a same-cycle software write.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_base <= MTVEC_RESET[31:2];
`ifdef CSR_VECTORED_EN
      mtvec_mode <= MTVEC_RESET[1:0];
`endif
      mscratch   <= '0;
      mepc_q     <= '0;
      mcause     <= '0;
      mtval      <= '0;
      mcycle     <= '0;
      minstret   <= '0;
    end else begin
      mip_q <= i_MEI;
      if (!cyc_wr) mcycle <= mcycle + 64'd1;
      if (i_RETIRE && !ins_wr) minstret <= minstret + 64'd1;
      if (wr_en) begin
        case (i_CSR_ADDR)
          12'h300: begin
            mst_mie  <= wr_val[3];
            mst_mpie <= wr_val[7];
          end
          12'h304: mie_q <= wr_val[N_IRQ-1:0];
          12'h305: begin
            mtvec_base <= wr_val[31:2];
`ifdef CSR_VECTORED_EN
            mtvec_mode <= wr_val[1:0];
`endif
          end
          12'h340: mscratch <= wr_val;
          12'h341: mepc_q <= wr_val[31:2];
          12'h342: mcause <= wr_val;
          12'h343: mtval <= wr_val;
          12'hB00: mcycle[31:0] <= wr_val;
          12'hB80: mcycle[63:32] <= wr_val;
          12'hB02: minstret[31:0] <= wr_val;
          12'hB82: minstret[63:32] <= wr_val;
          default: ;
        endcase
      end
      if (take) begin
        mepc_q   <= i_PC[31:2];
        mtval    <= i_INSTR;
        mcause   <= {1'b1, 27'd0, cause_k};
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (i_MRET) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end
    end
  end

endmodule
